// File: rtl/dco_pkg.sv
// Shared types and default sizing for the multi-channel digitally controlled
// oscillator block.
package dco_pkg;

    // Output shape selected per channel.
    typedef enum logic {
        MODE_SQUARE = 1'b0,  // 50% duty, MSB of the phase accumulator
        MODE_PULSE  = 1'b1   // one-cycle strobe per accumulator wrap
    } dco_mode_e;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_CODE_W = 8;
    localparam int DEF_ACC_W  = 12;

    // Channel index width; a single channel still gets a one-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_dco_if.sv
// Configuration handshake and per-channel outputs of multi_dco.
//
// Handshake: the master holds cfg_valid and cfg_ch/cfg_code/cfg_mode stable
// until it sees cfg_ready; one transfer happens on every rising clk edge where
// cfg_valid and cfg_ready are both high. cfg_ready may drop while cfg_valid is
// low and depends only on the addressed channel's pending flag.
interface multi_dco_if import dco_pkg::*; #(
    parameter int N_CH   = DEF_N_CH,
    parameter int CODE_W = DEF_CODE_W
);
    localparam int CH_W = ch_w(N_CH);

    logic              ena;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CODE_W-1:0] cfg_code;
    logic              cfg_mode;
    logic [N_CH-1:0]   dco_out;
    logic [N_CH-1:0]   wrap_pulse;
    logic [N_CH-1:0]   pending;

    modport master (
        output ena, cfg_valid, cfg_ch, cfg_code, cfg_mode,
        input  cfg_ready, dco_out, wrap_pulse, pending
    );

    modport slave (
        input  ena, cfg_valid, cfg_ch, cfg_code, cfg_mode,
        output cfg_ready, dco_out, wrap_pulse, pending
    );

endinterface

// File: rtl/dco_channel.sv
// One oscillator channel: phase accumulator, double-buffered code/mode with a
// pending flag, and the registered output mux. New settings take effect only
// at an accumulator wrap (or immediately when the channel is stopped), so the
// output never shows a shortened period.
module dco_channel import dco_pkg::*; #(
    parameter int CODE_W = DEF_CODE_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,     // active-high asynchronous reset
    input  logic              ena,
    input  logic              wr_en,     // accepted transfer addressed here
    input  logic [CODE_W-1:0] cfg_code,
    input  logic              cfg_mode,
    output logic              dco_o,
    output logic              wrap_o,
    output logic              pend_o
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] pcode_q, pcode_d;
    dco_mode_e         mode_q, mode_d;
    dco_mode_e         pmode_q, pmode_d;
    logic              pend_q, pend_d;
    logic              wrap_q, wrap_d;
    logic              dco_q, dco_d;

    logic [ACC_W:0]    sum;
    logic              run;
    logic              carry;
    logic              apply;

    // Next-state: accumulate, apply pending settings at wrap, capture writes.
    always_comb begin
        acc_d   = acc_q;
        code_d  = code_q;
        mode_d  = mode_q;
        pcode_d = pcode_q;
        pmode_d = pmode_q;
        pend_d  = pend_q;

        sum   = {1'b0, acc_q} + {1'b0, ACC_W'(code_q)};
        run   = ena && (code_q != '0);
        carry = run && sum[ACC_W];
        if (run) begin
            acc_d = sum[ACC_W-1:0];
        end
        wrap_d = carry;

        // A stopped channel picks up its pending setting on the next enabled
        // edge; a running one waits for its own wrap so the phase carries over.
        apply = ena && pend_q && ((code_q == '0) || carry);
        if (apply) begin
            code_d = pcode_q;
            mode_d = pmode_q;
            pend_d = 1'b0;
            if (code_q == '0) begin
                acc_d = '0;
            end
            if (pcode_q == '0) begin
                acc_d  = '0;
                wrap_d = 1'b0;
            end
        end

        // wr_en is only raised while pend_q is low, so it never races apply.
        if (wr_en) begin
            pcode_d = cfg_code;
            pmode_d = dco_mode_e'(cfg_mode);
            pend_d  = 1'b1;
        end

        dco_d = (mode_d == MODE_PULSE) ? wrap_d : acc_d[ACC_W-1];
    end

    // Channel state register with asynchronous clear.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q   <= '0;
            code_q  <= '0;
            mode_q  <= MODE_SQUARE;
            pcode_q <= '0;
            pmode_q <= MODE_SQUARE;
            pend_q  <= 1'b0;
            wrap_q  <= 1'b0;
            dco_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            code_q  <= code_d;
            mode_q  <= mode_d;
            pcode_q <= pcode_d;
            pmode_q <= pmode_d;
            pend_q  <= pend_d;
            wrap_q  <= wrap_d;
            dco_q   <= dco_d;
        end
    end

    assign dco_o  = dco_q;
    assign wrap_o = wrap_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/multi_dco.sv
// Multi-channel DCO top: decodes the configuration handshake and fans it out
// to N_CH independent dco_channel instances.
module multi_dco import dco_pkg::*; #(
    parameter int N_CH   = DEF_N_CH,
    parameter int CODE_W = DEF_CODE_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic         clk,
    input  logic         rst_n,    // active-high asynchronous reset
    multi_dco_if.slave   bus
);

    localparam int CH_W = ch_w(N_CH);

    if (ACC_W < CODE_W) begin : g_acc_w_check
        $error("multi_dco: ACC_W must be >= CODE_W");
    end
    if ((N_CH < 1) || (N_CH > 8)) begin : g_n_ch_check
        $error("multi_dco: N_CH must be in 1..8");
    end

    logic [N_CH-1:0] pend_w;
    logic [N_CH-1:0] dco_w;
    logic [N_CH-1:0] wrap_w;
    logic [N_CH-1:0] wr_en;
    logic            cfg_ready_c;

    // Ready follows the addressed channel; out-of-range writes are swallowed.
    always_comb begin
        cfg_ready_c = 1'b1;
        if (int'(bus.cfg_ch) < N_CH) begin
            cfg_ready_c = !pend_w[bus.cfg_ch];
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr_en[i] = bus.cfg_valid && cfg_ready_c && (bus.cfg_ch == CH_W'(i));

        dco_channel #(
            .CODE_W (CODE_W),
            .ACC_W  (ACC_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (bus.ena),
            .wr_en    (wr_en[i]),
            .cfg_code (bus.cfg_code),
            .cfg_mode (bus.cfg_mode),
            .dco_o    (dco_w[i]),
            .wrap_o   (wrap_w[i]),
            .pend_o   (pend_w[i])
        );
    end

    assign bus.cfg_ready  = cfg_ready_c;
    assign bus.dco_out    = dco_w;
    assign bus.wrap_pulse = wrap_w;
    assign bus.pending    = pend_w;

endmodule

// File: tb/tb_multi_dco.sv
// Bench for multi_dco (N_CH=4, CODE_W=8, ACC_W=8): a hand-derived vector table
// for the first configurations, directed sequences for wrap/ena/reset corner
// cases, and a randomized run, all checked against a cycle model built from
// the accumulator arithmetic.
module tb_multi_dco;
    import dco_pkg::*;

    localparam int N_CH    = 4;
    localparam int CODE_W  = 8;
    localparam int ACC_W   = 8;
    localparam int ACC_MOD = 1 << ACC_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    multi_dco_if #(.N_CH(N_CH), .CODE_W(CODE_W)) bus();

    multi_dco #(.N_CH(N_CH), .CODE_W(CODE_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic last_rdy;

    // ---------------- reference model ----------------
    int m_acc[N_CH], m_code[N_CH], m_mode[N_CH], m_pcode[N_CH], m_pmode[N_CH];
    bit m_pend[N_CH], m_wrap[N_CH], m_dco[N_CH];

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_acc[i] = 0; m_code[i] = 0; m_mode[i] = 0; m_pcode[i] = 0; m_pmode[i] = 0;
            m_pend[i] = 0; m_wrap[i] = 0; m_dco[i] = 0;
        end
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        for (int i = 0; i < N_CH; i++) begin
            bit wr, carry, apply, running;
            int total, nacc;
            wr      = bus.cfg_valid && !m_pend[i] && (int'(bus.cfg_ch) == i);
            running = bus.ena && (m_code[i] != 0);
            total   = m_acc[i] + m_code[i];
            carry   = running && (total >= ACC_MOD);
            nacc    = running ? (total % ACC_MOD) : m_acc[i];
            m_wrap[i] = carry;
            apply   = bus.ena && m_pend[i] && ((m_code[i] == 0) || carry);
            if (apply) begin
                m_code[i] = m_pcode[i];
                m_mode[i] = m_pmode[i];
                m_pend[i] = 0;
                if (m_code[i] == 0) begin
                    nacc = 0;
                    m_wrap[i] = 0;
                end
            end
            if (wr) begin
                m_pcode[i] = int'(bus.cfg_code);
                m_pmode[i] = int'(bus.cfg_mode);
                m_pend[i]  = 1;
            end
            m_acc[i] = nacc;
            m_dco[i] = (m_mode[i] == 1) ? m_wrap[i] : (nacc >= ACC_MOD / 2);
        end
    endfunction

    function automatic logic [3*N_CH-1:0] exp_vec();
        logic [N_CH-1:0] d, w, p;
        for (int i = 0; i < N_CH; i++) begin
            d[i] = m_dco[i]; w[i] = m_wrap[i]; p[i] = m_pend[i];
        end
        return {d, w, p};
    endfunction

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e, input logic v, input int ch, input int code, input logic md);
        bus.ena       = e;
        bus.cfg_valid = v;
        bus.cfg_ch    = ch[1:0];
        bus.cfg_code  = code[7:0];
        bus.cfg_mode  = md;
    endtask

    // One clock: check ready before the edge, advance model, check outputs after.
    task automatic step();
        #1;
        last_rdy = bus.cfg_ready;
        check("cfg_ready", 32'(bus.cfg_ready), 32'(!m_pend[int'(bus.cfg_ch)]));
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        check("outputs", 32'({bus.dco_out, bus.wrap_pulse, bus.pending}), 32'(exp_vec()));
    endtask

    // Steps until wrap_pulse[0] is seen; returns the step count or -1.
    task automatic wait_wrap0(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (bus.wrap_pulse[0]) begin
                n = k;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic ena; logic valid; int ch; int code; logic mode;
        logic dco0; logic wrap0; logic pend0; logic rdy;
    } vec_t;
    vec_t tbl[22];

    function automatic vec_t v(input logic valid, input int code,
                               input logic d, input logic w, input logic p, input logic r);
        vec_t t;
        t.ena = 1'b1; t.valid = valid; t.ch = 0; t.code = code; t.mode = 1'b0;
        t.dco0 = d; t.wrap0 = w; t.pend0 = p; t.rdy = r;
        return t;
    endfunction

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int n, last_hi, n_hi, guard, code, r;
        logic prev, snap0;

        // Ch0: code 64 square from idle, then retune to 32 while running.
        tbl[0]  = v(1, 64, 0, 0, 1, 1);  tbl[1]  = v(0, 0, 0, 0, 0, 0);
        tbl[2]  = v(0, 0, 0, 0, 0, 1);   tbl[3]  = v(0, 0, 1, 0, 0, 1);
        tbl[4]  = v(0, 0, 1, 0, 0, 1);   tbl[5]  = v(0, 0, 0, 1, 0, 1);
        tbl[6]  = v(0, 0, 0, 0, 0, 1);   tbl[7]  = v(0, 0, 1, 0, 0, 1);
        tbl[8]  = v(0, 0, 1, 0, 0, 1);   tbl[9]  = v(0, 0, 0, 1, 0, 1);
        tbl[10] = v(1, 32, 0, 0, 1, 1);  tbl[11] = v(0, 0, 1, 0, 1, 0);
        tbl[12] = v(0, 0, 1, 0, 1, 0);   tbl[13] = v(0, 0, 0, 1, 0, 0);
        tbl[14] = v(0, 0, 0, 0, 0, 1);   tbl[15] = v(0, 0, 0, 0, 0, 1);
        tbl[16] = v(0, 0, 0, 0, 0, 1);   tbl[17] = v(0, 0, 1, 0, 0, 1);
        tbl[18] = v(0, 0, 1, 0, 0, 1);   tbl[19] = v(0, 0, 1, 0, 0, 1);
        tbl[20] = v(0, 0, 1, 0, 0, 1);   tbl[21] = v(0, 0, 0, 1, 0, 1);

        // Reset held, then 1000 idle cycles.
        model_reset();
        drive(1, 0, 0, 0, 0);
        #1;
        check("reset_outputs", 32'({bus.dco_out, bus.wrap_pulse, bus.pending}), 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 32'({bus.dco_out, bus.wrap_pulse, bus.pending}), 0);
        check("reset_ready", 32'(bus.cfg_ready), 1);
        #2 rst_n = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            drive(1, 0, $urandom_range(0, N_CH - 1), $urandom_range(0, 255), 0);
            step();
        end

        // Table-driven ch0 sequence.
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].ena, tbl[i].valid, tbl[i].ch, tbl[i].code, tbl[i].mode);
            step();
            check($sformatf("tbl_row%0d", i),
                  32'({bus.dco_out[0], bus.wrap_pulse[0], bus.pending[0], last_rdy}),
                  32'({tbl[i].dco0, tbl[i].wrap0, tbl[i].pend0, tbl[i].rdy}));
        end

        // Ch1 code 1 pulse mode: one-cycle pulse every 256 cycles.
        drive(1, 1, 1, 1, 1);
        step();
        drive(1, 0, 0, 0, 0);
        last_hi = -1; n_hi = 0; prev = 1'b0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (bus.dco_out[1]) begin
                check("pulse_width", 32'(prev), 0);
                if (last_hi >= 0) check("pulse_period", k - last_hi, 256);
                last_hi = k;
                n_hi++;
            end
            prev = bus.dco_out[1];
        end
        check("pulse_count", n_hi, 2);

        // Transfer on the same edge as a ch0 wrap: old code runs one more period.
        guard = 0;
        while ((m_acc[0] + m_code[0]) < ACC_MOD && guard < 40) begin
            step();
            guard++;
        end
        check("sync_to_wrap", 32'(guard < 40), 1);
        drive(1, 1, 0, 64, 0);
        step();
        drive(1, 0, 0, 0, 0);
        check("coinc_wrap", 32'(bus.wrap_pulse[0]), 1);
        check("coinc_pend", 32'(bus.pending[0]), 1);
        wait_wrap0(20, n);
        check("old_period", n, 8);
        check("applied_at_wrap", 32'(bus.pending[0]), 0);
        wait_wrap0(20, n);
        check("new_period", n, 4);

        // ena=0 for 10 cycles; a write to ch2 during the freeze stays pending.
        repeat (2) step();
        snap0 = bus.dco_out[0];
        for (int k = 0; k < 10; k++) begin
            if (k == 3) drive(0, 1, 2, 128, 0);
            else        drive(0, 0, 0, 0, 0);
            step();
            check("freeze_dco0", 32'(bus.dco_out[0]), 32'(snap0));
            check("freeze_wrap", 32'(bus.wrap_pulse), 0);
        end
        check("freeze_pend2", 32'(bus.pending[2]), 1);
        drive(1, 0, 0, 0, 0);
        step();
        check("resume_apply2", 32'(bus.pending[2]), 0);
        repeat (20) step();

        // Reset mid-period with a pending retune on ch0.
        drive(1, 1, 0, 16, 0);
        step();
        drive(1, 0, 0, 0, 0);
        check("pre_reset_pend", 32'(bus.pending[0]), 1);
        #2 rst_n = 1'b1;
        #1;
        check("async_reset", 32'({bus.dco_out, bus.wrap_pulse, bus.pending}), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_mid_hold", 32'({bus.dco_out, bus.wrap_pulse, bus.pending}), 0);
        #2 rst_n = 1'b0;
        repeat (50) step();
        check("no_restart", 32'({bus.dco_out, bus.wrap_pulse, bus.pending}), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      code = 0;
            else if (r < 5) code = 1 << $urandom_range(0, 7);
            else            code = $urandom_range(1, 255);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, N_CH - 1), code, 1'($urandom_range(0, 1)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_dco.md
MULTI_DCO -- requirements
Module: multi_dco

Interface
REQ-001 Parameter N_CH, default 4: number of independent oscillator channels (1..8).
REQ-002 Parameter CODE_W, default 8: frequency control word width.
REQ-003 Parameter ACC_W, default 12: phase accumulator width; ACC_W >= CODE_W SHALL be enforced by elaboration check.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous and active-high (port name retained from top-level convention).
REQ-006 ena  input  1  global run enable; 0 freezes all channel state.
REQ-007 cfg_valid  input  1  configuration request.
REQ-008 cfg_ready  output  1  configuration accept; transfer occurs when cfg_valid & cfg_ready.
REQ-009 cfg_ch  input  max(1,$clog2(N_CH))  target channel index; values >= N_CH are accepted and discarded.
REQ-010 cfg_code  input  CODE_W  new frequency code; 0 = channel stopped.
REQ-011 cfg_mode  input  1  output mode: 0 = square (50% duty), 1 = pulse (one cycle per period).
REQ-012 dco_out  output  N_CH  per-channel oscillator output.
REQ-013 wrap_pulse  output  N_CH  one-cycle strobe per channel on phase accumulator overflow.
REQ-014 pending  output  N_CH  per-channel flag: accepted configuration not yet applied.

Function
REQ-015 Each channel SHALL hold active code, active mode, pending code/mode, pending flag and ACC_W-bit accumulator acc.
REQ-016 When ena=1 and active code != 0, each clock SHALL update acc <= (acc + code) mod 2^ACC_W; carry = overflow of that add.
REQ-017 wrap_pulse[i] SHALL be registered carry: high in the cycle after the edge where overflow occurred, for exactly one cycle.
REQ-018 Square mode: dco_out[i] SHALL equal acc[ACC_W-1] (registered, no combinational path); pulse mode: dco_out[i] SHALL equal wrap_pulse[i].
REQ-019 Output period SHALL be 2^ACC_W / code cycles when code divides 2^ACC_W; otherwise average frequency f_clk*code/2^ACC_W.
REQ-020 cfg_ready SHALL be !pending[cfg_ch] combinationally (1 for out-of-range cfg_ch).
REQ-021 On transfer, pending code/mode SHALL be stored and pending[ch] set on the next edge.
REQ-022 If the channel's active code is 0, the pending value SHALL be applied on the edge after the transfer edge, with acc reset to 0.
REQ-023 Otherwise the pending value SHALL be applied at the edge where carry=1; acc keeps the wrapped remainder (phase-continuous, glitch-free).
REQ-024 Applying new code 0 SHALL clear acc and force dco_out[i]=0 and wrap_pulse[i]=0 from the next cycle.
REQ-025 Transfer and wrap on the same channel in the same cycle: new value becomes pending and SHALL be applied at the following wrap, not the current one.
REQ-026 ena=0: acc, outputs and active/pending registers SHALL hold; wrap_pulse SHALL be 0; handshake SHALL still accept into non-pending channels; application SHALL be deferred until ena=1.
REQ-027 Channels SHALL be fully independent; a transfer to one channel SHALL not disturb another's phase.

Reset
REQ-028 rst_n=1 SHALL asynchronously clear acc, active codes, modes, pending registers; dco_out, wrap_pulse and pending outputs SHALL be 0 while asserted and on the first cycle after release.
REQ-029 Reset asserted mid-period SHALL discard pending configurations; no wrap_pulse SHALL be produced by reset release.

Structure
REQ-030 Package dco_pkg SHALL hold mode enum (MODE_SQUARE=0, MODE_PULSE=1) and default parameter constants.
REQ-031 One sub-module dco_channel (accumulator, pending logic, output mux) SHALL be instantiated N_CH times; the top holds handshake decode only.

Verification (bench: N_CH=4, CODE_W=8, ACC_W=8)
REQ-032 Reset, no config -> dco_out=0, wrap_pulse=0, pending=0, cfg_ready=1 for 1000 cycles.
REQ-033 Ch0 code 64 square -> applied one cycle after transfer; dco_out[0] 2 high / 2 low, wrap_pulse[0] every 4 cycles.
REQ-034 Ch1 code 1 pulse -> single-cycle dco_out[1] every 256 cycles; ch0 phase unaffected.
REQ-035 Ch0 running code 64, write code 32 -> pending[0]=1 and cfg_ready=0 for ch0 until next wrap; period 8 thereafter, no short/runt period.
REQ-036 Transfer coincident with wrap -> old code holds one more full period; ena=0 for 10 cycles -> outputs frozen, resume at same phase.
REQ-037 rst_n pulse mid-period with pending set -> all outputs 0, pending cleared, restart requires new configuration.
